// File: rtl/bp_trace_pkg.sv
// Shared types for the trace-driven branch-predictor driver.
// The record struct is a macro so each user sizes the index to its own table.
`define BP_TRACE_REC_S(idx_width) \
    struct packed { \
        logic [(idx_width)-1:0] idx; \
        logic                   taken; \
        logic                   last; \
    }

package bp_trace_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_read,
        e_wait,
        e_update
    } bp_trace_state_e;

    localparam int unsigned WaitCntWidth = 4;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module bp_sat_counter #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               inc_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;
    logic               w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (inc_i && !w_at_max) begin
            r_count <= r_count + width_p'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bp_fe_bp_trace_driver.sv
// Replays resolved-branch trace records through a predictor: read, wait for the
// prediction, then write back correct/incorrect and accumulate accuracy stats.
module bp_fe_bp_trace_driver
    import bp_trace_pkg::*;
#(
    parameter int unsigned bht_idx_width_p = 2,
    parameter int unsigned read_latency_p  = 1,
    parameter int unsigned cnt_width_p     = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       trace_v_i,
    output logic                       trace_ready_o,
    input  logic [bht_idx_width_p-1:0] trace_idx_i,
    input  logic                       trace_taken_i,
    input  logic                       trace_last_i,
    output logic                       r_v_o,
    output logic [bht_idx_width_p-1:0] idx_r_o,
    input  logic                       predict_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic [cnt_width_p-1:0]     branch_cnt_o,
    output logic [cnt_width_p-1:0]     mispredict_cnt_o,
    output logic                       done_o
);

    typedef `BP_TRACE_REC_S(bht_idx_width_p) trace_rec_t;

    localparam logic [WaitCntWidth-1:0] WaitLoad = WaitCntWidth'(read_latency_p - 1);

    bp_trace_state_e          r_state, w_state_next;
    trace_rec_t               r_rec, w_rec_next;
    logic [WaitCntWidth-1:0]  r_wait, w_wait_next;
    logic                     r_pred, w_pred_next;
    logic                     r_done, w_done_next;

    logic w_is_idle, w_is_read, w_is_update, w_correct;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_rec   <= '0;
            r_wait  <= '0;
            r_pred  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rec   <= w_rec_next;
            r_wait  <= w_wait_next;
            r_pred  <= w_pred_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rec_next   = r_rec;
        w_wait_next  = r_wait;
        w_pred_next  = r_pred;
        w_done_next  = r_done;
        unique case (r_state)
            e_idle: begin
                if (trace_v_i && !r_done) begin
                    w_rec_next.idx   = trace_idx_i;
                    w_rec_next.taken = trace_taken_i;
                    w_rec_next.last  = trace_last_i;
                    w_state_next     = e_read;
                end
            end
            e_read: begin
                w_wait_next  = WaitLoad;
                w_state_next = e_wait;
            end
            e_wait: begin
                // predict_i is only meaningful on the cycle the countdown reaches zero
                if (r_wait == '0) begin
                    w_pred_next  = predict_i;
                    w_state_next = e_update;
                end else begin
                    w_wait_next = r_wait - WaitCntWidth'(1);
                end
            end
            e_update: begin
                if (r_rec.last) begin
                    w_done_next = 1'b1;
                end
                w_state_next = e_idle;
            end
            default: w_state_next = e_idle;
        endcase
    end

    assign w_is_idle   = (r_state == e_idle);
    assign w_is_read   = (r_state == e_read);
    assign w_is_update = (r_state == e_update);
    assign w_correct   = (r_pred == r_rec.taken);

    assign trace_ready_o = w_is_idle & ~r_done;
    assign r_v_o         = w_is_read;
    assign idx_r_o       = w_is_read ? r_rec.idx : '0;
    assign w_v_o         = w_is_update;
    assign idx_w_o       = w_is_update ? r_rec.idx : '0;
    assign correct_o     = w_is_update & w_correct;
    assign done_o        = r_done;

    bp_sat_counter #(
        .width_p (cnt_width_p)
    ) u_branch_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (1'b0),
        .inc_i   (w_is_update),
        .count_o (branch_cnt_o)
    );

    bp_sat_counter #(
        .width_p (cnt_width_p)
    ) u_mispredict_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (1'b0),
        .inc_i   (w_is_update & ~w_correct),
        .count_o (mispredict_cnt_o)
    );

endmodule

// File: tb/tb_bp_fe_bp_trace_driver.sv
// Two drivers: instance 0 at read latency 1 with wide counters, instance 1 at
// read latency 3 with 2-bit counters so saturation is reachable.
module tb_bp_fe_bp_trace_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst    [2];
    logic       tv     [2];
    logic [1:0] tidx   [2];
    logic       ttaken [2];
    logic       tlast  [2];
    logic       pred   [2];
    logic       ready  [2];
    logic       rv     [2];
    logic [1:0] idxr   [2];
    logic       wv     [2];
    logic [1:0] idxw   [2];
    logic       corr   [2];
    logic       done   [2];
    logic [31:0] brc0, mis0;
    logic [1:0]  brc1, mis1;

    bp_fe_bp_trace_driver #(
        .bht_idx_width_p (2),
        .read_latency_p  (1),
        .cnt_width_p     (32)
    ) dut0 (
        .clk_i            (clk),
        .reset_i          (rst[0]),
        .trace_v_i        (tv[0]),
        .trace_ready_o    (ready[0]),
        .trace_idx_i      (tidx[0]),
        .trace_taken_i    (ttaken[0]),
        .trace_last_i     (tlast[0]),
        .r_v_o            (rv[0]),
        .idx_r_o          (idxr[0]),
        .predict_i        (pred[0]),
        .w_v_o            (wv[0]),
        .idx_w_o          (idxw[0]),
        .correct_o        (corr[0]),
        .branch_cnt_o     (brc0),
        .mispredict_cnt_o (mis0),
        .done_o           (done[0])
    );

    bp_fe_bp_trace_driver #(
        .bht_idx_width_p (2),
        .read_latency_p  (3),
        .cnt_width_p     (2)
    ) dut1 (
        .clk_i            (clk),
        .reset_i          (rst[1]),
        .trace_v_i        (tv[1]),
        .trace_ready_o    (ready[1]),
        .trace_idx_i      (tidx[1]),
        .trace_taken_i    (ttaken[1]),
        .trace_last_i     (tlast[1]),
        .r_v_o            (rv[1]),
        .idx_r_o          (idxr[1]),
        .predict_i        (pred[1]),
        .w_v_o            (wv[1]),
        .idx_w_o          (idxw[1]),
        .correct_o        (corr[1]),
        .branch_cnt_o     (brc1),
        .mispredict_cnt_o (mis1),
        .done_o           (done[1])
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          lat      [2] = '{1, 3};
    longint      cmax     [2] = '{64'hFFFF_FFFF, 3};
    longint      exp_br   [2] = '{0, 0};
    longint      exp_mis  [2] = '{0, 0};
    bit          exp_done [2] = '{0, 0};
    int          last_acc [2] = '{-1, -1};

    function automatic logic [31:0] br_of(int i);
        return (i == 0) ? brc0 : {30'b0, brc1};
    endfunction

    function automatic logic [31:0] mis_of(int i);
        return (i == 0) ? mis0 : {30'b0, mis1};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_counts(int i);
        check("branch_cnt", br_of(i), 32'(exp_br[i]));
        check("mispredict_cnt", mis_of(i), 32'(exp_mis[i]));
        check("done", 32'(done[i]), 32'(exp_done[i]));
    endtask

    // One record end to end; the predictor model answers pv only on the sample cycle.
    task automatic do_record(int i, logic [1:0] idx, logic tk, logic lst, logic pv, bit hold);
        int acc;
        tv[i] = 1'b1; tidx[i] = idx; ttaken[i] = tk; tlast[i] = lst;
        check("ready_before_accept", 32'(ready[i]), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) tv[i] = 1'b0;
        if (hold && last_acc[i] >= 0) check("accept_spacing", 32'(acc - last_acc[i]), 32'(3 + lat[i]));
        last_acc[i] = acc;
        for (int c = 1; c <= 3 + lat[i]; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            pred[i] = (c == 1 + lat[i]) ? pv : ~pv;
            @(negedge clk);
            check("r_v", 32'(rv[i]), 32'(c == 1));
            check("idx_r", 32'(idxr[i]), (c == 1) ? 32'(idx) : 32'd0);
            check("w_v", 32'(wv[i]), 32'(c == 2 + lat[i]));
            check("idx_w", 32'(idxw[i]), (c == 2 + lat[i]) ? 32'(idx) : 32'd0);
            check("correct", 32'(corr[i]), 32'((c == 2 + lat[i]) && (pv == tk)));
            check("ready", 32'(ready[i]), (c == 3 + lat[i]) ? 32'(!exp_done[i]) : 32'd0);
            check_counts(i);
            if (c == 2 + lat[i]) begin
                exp_br[i] = (exp_br[i] + 1 > cmax[i]) ? cmax[i] : exp_br[i] + 1;
                if (pv != tk) exp_mis[i] = (exp_mis[i] + 1 > cmax[i]) ? cmax[i] : exp_mis[i] + 1;
                if (lst) exp_done[i] = 1'b1;
            end
        end
    endtask

    task automatic do_reset(int i);
        rst[i] = 1'b1;
        #1;
        exp_br[i] = 0; exp_mis[i] = 0; exp_done[i] = 1'b0; last_acc[i] = -1;
        check("rst_r_v", 32'(rv[i]), 32'd0);
        check("rst_w_v", 32'(wv[i]), 32'd0);
        check("rst_idx_r", 32'(idxr[i]), 32'd0);
        check("rst_ready", 32'(ready[i]), 32'd1);
        check_counts(i);
        @(posedge clk); #1;
        rst[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; tv[i] = 1'b0; tidx[i] = '0; ttaken[i] = 1'b0;
            tlast[i] = 1'b0; pred[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("init_ready", 32'(ready[i]), 32'd1);
            check("init_r_v", 32'(rv[i]), 32'd0);
            check("init_w_v", 32'(wv[i]), 32'd0);
            check_counts(i);
        end

        // Single record, correct prediction at latency 1.
        do_record(0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("single_branch", br_of(0), 32'd1);
        check("single_mispredict", mis_of(0), 32'd0);

        for (int k = 0; k < 8; k++) begin
            do_record(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
                      1'($urandom_range(0, 1)), 1'b0);
        end

        // Back-to-back stream with valid held high.
        do_reset(0);
        for (int k = 0; k < 4; k++) begin
            do_record(0, 2'(k), 1'(k % 2 == 0), 1'b0, 1'b1, 1'b1);
        end
        tv[0] = 1'b0;
        check("stream_branch", br_of(0), 32'd4);
        check("stream_mispredict", mis_of(0), 32'd2);

        // Last record on the second, then a third offer must be ignored.
        do_reset(0);
        do_record(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
                  1'($urandom_range(0, 1)), 1'b0);
        do_record(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1,
                  1'($urandom_range(0, 1)), 1'b0);
        check("done_after_last", 32'(done[0]), 32'd1);
        tv[0] = 1'b1; tidx[0] = 2'd3;
        repeat (6) begin
            @(negedge clk);
            check("done_ready_low", 32'(ready[0]), 32'd0);
            check("done_no_read", 32'(rv[0]), 32'd0);
            check_counts(0);
        end
        tv[0] = 1'b0;

        // Longer read latency: predictor shows 0 only on the sample cycle.
        do_record(1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lat3_mispredict", mis_of(1), 32'd0);

        // Reset while waiting for the prediction drops the record.
        tv[1] = 1'b1; tidx[1] = 2'd2; ttaken[1] = 1'b1; tlast[1] = 1'b0;
        @(posedge clk); #1;
        tv[1] = 1'b0;
        @(negedge clk);
        check("midwait_r_v", 32'(rv[1]), 32'd1);
        @(posedge clk); #1;
        do_reset(1);
        repeat (6) begin
            @(negedge clk);
            check("midwait_no_w_v", 32'(wv[1]), 32'd0);
            check("midwait_ready", 32'(ready[1]), 32'd1);
            check_counts(1);
        end

        // Saturation of 2-bit counters; done still sets on the fifth record.
        for (int k = 0; k < 5; k++) begin
            logic tk;
            tk = 1'($urandom_range(0, 1));
            do_record(1, 2'($urandom_range(0, 3)), tk, 1'(k == 4), ~tk, 1'b0);
        end
        check("sat_branch", br_of(1), 32'd3);
        check("sat_mispredict", mis_of(1), 32'd3);
        check("sat_done", 32'(done[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
